// File: rtl/debug_led_view.sv
// Debug LED viewer: synchronised, debounced keys select a debug byte.
// A long two-key hold toggles a frozen snapshot of all three bytes.
module debug_led_view #(
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int LONG_CYCLES     = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] keys_n,
  input  logic [7:0] debug_status,
  input  logic [7:0] debug_bus1,
  input  logic [7:0] debug_bus2,
  output logic [7:0] leds,
  output logic [1:0] view,
  output logic       frozen
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LLAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LMAX  = LW'(LONG_CYCLES);

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [DW-1:0] dcnt [2];
  logic [LW-1:0] ccnt;
  logic [LW-1:0] ccnt_next;
  logic [7:0]    snap_status;
  logic [7:0]    snap_bus1;
  logic [7:0]    snap_bus2;

  logic [1:0] pressed;
  logic       both;
  logic       toggle;
  logic       snap_load;
  logic       frozen_next;
  logic [1:0] view_next;
  logic [7:0] src_status;
  logic [7:0] src_bus1;
  logic [7:0] src_bus2;
  logic [7:0] leds_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb     <= 2'b11;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= keys_n;
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == deb[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DLAST) begin
          deb[k]  <= sync2[k];
          dcnt[k] <= '0;
        end else begin
          dcnt[k] <= dcnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pressed   = ~deb;
    both      = &pressed;
    view_next = 2'd0;
    if (pressed[0]) begin
      view_next = 2'd1;
    end else if (pressed[1]) begin
      view_next = 2'd2;
    end
    ccnt_next = '0;
    if (both) begin
      ccnt_next = (ccnt == LMAX) ? ccnt : ccnt + 1'b1;
    end
    toggle      = both && (ccnt == LLAST);
    frozen_next = frozen ^ toggle;
    snap_load   = toggle && !frozen;
    // The freezing edge itself shows the bytes being captured.
    if (frozen_next && !snap_load) begin
      src_status = snap_status;
      src_bus1   = snap_bus1;
      src_bus2   = snap_bus2;
    end else begin
      src_status = debug_status;
      src_bus1   = debug_bus1;
      src_bus2   = debug_bus2;
    end
    leds_next = src_status;
    if (view_next == 2'd1) begin
      leds_next = src_bus1;
    end else if (view_next == 2'd2) begin
      leds_next = src_bus2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccnt        <= '0;
      frozen      <= 1'b0;
      view        <= 2'd0;
      leds        <= 8'h00;
      snap_status <= 8'h00;
      snap_bus1   <= 8'h00;
      snap_bus2   <= 8'h00;
    end else begin
      ccnt   <= ccnt_next;
      frozen <= frozen_next;
      view   <= view_next;
      leds   <= leds_next;
      if (snap_load) begin
        snap_status <= debug_status;
        snap_bus1   <= debug_bus1;
        snap_bus2   <= debug_bus2;
      end
    end
  end

endmodule
